hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on posedge.
REQ-002 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have ports: id_rs_used, id_rt_used  in  1 each  ID instruction reads rs / rt.
REQ-005 SHALL have ports: ex_WE  in  1, ex_RW  in  5, ex_load  in  1  write enable, destination and load flag of the EX-stage instruction.
REQ-006 SHALL have port: branch_taken  in  1  taken branch or jump resolved in EX this cycle.
REQ-007 SHALL have ports: wb_syscall, wb_halt  in  1 each  syscall in WB; halt code present.
REQ-008 SHALL have port: resume  in  1  level; leaves HALT.
REQ-009 SHALL have ports: go_pc, go_if_id, go_id_ex, go_ex_mem, go_mem_wb  out  1 each  stage-register load enables.
REQ-010 SHALL have ports: clear_if_id, clear_id_ex, clear_mem_wb  out  1 each  bubble inserts; each takes effect only when the matching go is 1.
REQ-011 SHALL have ports: halted  out  1, stall_cnt  out  16, flush_cnt  out  16.

Function
REQ-012 SHALL implement a 2-state FSM: RUN and HALT.
REQ-013 SHALL detect load-use (lu) when ex_load & ex_WE & ex_RW!=0 & ((id_rs_used & id_rs==ex_RW) | (id_rt_used & id_rt==ex_RW)).
REQ-014 SHALL, in RUN with no lu, no branch_taken and no halt: all go=1, all clear=0.
REQ-015 SHALL, on lu (RUN, no branch_taken, no halt): go_pc=0, go_if_id=0, clear_id_ex=1; all other go=1; 1 bubble per detection; lu is re-evaluated the next cycle.
REQ-016 SHALL, on branch_taken (RUN, no halt): all go=1, clear_if_id=1, clear_id_ex=1; branch_taken overrides lu in the same cycle.
REQ-017 SHALL, on wb_syscall & wb_halt in RUN (detection cycle): go_pc, go_if_id, go_id_ex, go_ex_mem=0; go_mem_wb=1 and clear_mem_wb=1 to retire the syscall; state->HALT. This overrides branch_taken and lu.
REQ-018 SHALL drive all go=0 and all clear=0 in HALT; halted=1 only in HALT.
REQ-019 SHALL move HALT->RUN on the edge where resume=1; normal outputs resume in the next cycle; resume is ignored in RUN.
REQ-020 SHALL ignore wb_syscall while wb_halt=0.
REQ-021 SHALL compute all go/clear combinationally from the current state and inputs; no added latency.
REQ-022 SHALL increment stall_cnt by 1 per cycle in which REQ-015 applies, saturating at 16'hFFFF.
REQ-023 SHALL increment flush_cnt by 1 per cycle in which REQ-016 applies, saturating at 16'hFFFF.
REQ-024 SHALL leave the counters unchanged in HALT and in the detection cycle.

Reset
REQ-025 SHALL, on rst_n=0 and independent of clk, set state=RUN, stall_cnt=0 and flush_cnt=0.
REQ-026 SHALL drive halted=0 while rst_n=0; go/clear then follow RUN rules.
REQ-027 SHALL leave HALT to RUN when reset is asserted mid-HALT; counters clear.

Configuration
REQ-028 SHALL gate the counters with macro HAZARD_PERF_CNT_EN: defined -> REQ-022/023 counters present; undefined -> no counter flops, and stall_cnt and flush_cnt tied to 16'h0000.

Verification
REQ-029 SHALL cover load-use: ex_load=1, ex_WE=1, ex_RW=8, id_rs=8, id_rs_used=1 for 1 cycle -> go_pc=0, go_if_id=0, clear_id_ex=1, stall_cnt 0->1.
REQ-030 SHALL cover ex_RW=0 with the same match on register 0 -> no stall, all go=1, stall_cnt unchanged.
REQ-031 SHALL cover branch_taken=1 together with the lu of REQ-029 -> all go=1, clear_if_id=1, clear_id_ex=1, flush_cnt+1, stall_cnt unchanged.
REQ-032 SHALL cover wb_syscall=1, wb_halt=1 -> same cycle go_mem_wb=1, clear_mem_wb=1, other go=0; next cycle halted=1, all go=0; resume=1 for 1 cycle -> halted=0 and all go=1 the following cycle.
REQ-033 SHALL cover rst_n pulsed low mid-HALT with clk stopped -> halted=0 and counters=0 immediately.
REQ-034 SHALL cover 65536 consecutive lu cycles with HAZARD_PERF_CNT_EN defined -> stall_cnt holds at 16'hFFFF; rerun undefined -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: stage hazard inputs toward the controller,
// stage-register enables/bubbles and perf counters back out.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        ex_WE;
  logic [4:0]  ex_RW;
  logic        ex_load;
  logic        branch_taken;
  logic        wb_syscall;
  logic        wb_halt;
  logic        resume;
  logic        go_pc;
  logic        go_if_id;
  logic        go_id_ex;
  logic        go_ex_mem;
  logic        go_mem_wb;
  logic        clear_if_id;
  logic        clear_id_ex;
  logic        clear_mem_wb;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, ex_WE, ex_RW, ex_load,
           branch_taken, wb_syscall, wb_halt, resume,
    input  go_pc, go_if_id, go_id_ex, go_ex_mem, go_mem_wb,
           clear_if_id, clear_id_ex, clear_mem_wb, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, ex_WE, ex_RW, ex_load,
           branch_taken, wb_syscall, wb_halt, resume,
    output go_pc, go_if_id, go_id_ex, go_ex_mem, go_mem_wb,
           clear_if_id, clear_id_ex, clear_mem_wb, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch flush, syscall halt.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
//
// state | meaning
// RUN   | pipeline advancing; stall/flush/halt detection active
// HALT  | pipeline frozen after a halting syscall retired; waits for resume
module hazard_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  hz
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t state, state_nxt;
  logic   lu;
  logic   halt_det;
  logic   stall_inc;
  logic   flush_inc;

  assign lu = hz.ex_load & hz.ex_WE & (hz.ex_RW != 5'd0) &
              ((hz.id_rs_used & (hz.id_rs == hz.ex_RW)) |
               (hz.id_rt_used & (hz.id_rt == hz.ex_RW)));
  assign halt_det = hz.wb_syscall & hz.wb_halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    hz.go_pc         = 1'b0;
    hz.go_if_id      = 1'b0;
    hz.go_id_ex      = 1'b0;
    hz.go_ex_mem     = 1'b0;
    hz.go_mem_wb     = 1'b0;
    hz.clear_if_id   = 1'b0;
    hz.clear_id_ex   = 1'b0;
    hz.clear_mem_wb  = 1'b0;
    stall_inc        = 1'b0;
    flush_inc        = 1'b0;
    case (state)
      RUN: begin
        if (halt_det) begin
          // only WB advances, retiring the syscall as a bubble
          hz.go_mem_wb    = 1'b1;
          hz.clear_mem_wb = 1'b1;
          state_nxt       = HALT;
        end else begin
          hz.go_pc     = 1'b1;
          hz.go_if_id  = 1'b1;
          hz.go_id_ex  = 1'b1;
          hz.go_ex_mem = 1'b1;
          hz.go_mem_wb = 1'b1;
          if (hz.branch_taken) begin
            hz.clear_if_id = 1'b1;
            hz.clear_id_ex = 1'b1;
            flush_inc      = 1'b1;
          end else if (lu) begin
            hz.go_pc       = 1'b0;
            hz.go_if_id    = 1'b0;
            hz.clear_id_ex = 1'b1;
            stall_inc      = 1'b1;
          end
        end
      end
      HALT: begin
        if (hz.resume) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign hz.halted = (state == HALT);

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'h0000;
      flush_q <= 16'h0000;
    end else begin
      if (stall_inc && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
      if (flush_inc && flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;
`else
  logic unused_inc;
  assign unused_inc   = stall_inc ^ flush_inc;
  assign hz.stall_cnt = 16'h0000;
  assign hz.flush_cnt = 16'h0000;
`endif

endmodule
